// File: rtl/game_sequencer_pkg.sv
// Shared state codes and constants for the
// per-frame game loop sequencer.
package game_pkg;

  typedef enum logic [3:0] {
    S_INIT          = 4'd0,
    S_IDLE          = 4'd1,
    S_GEN_MOVE      = 4'd2,
    S_CHECK_COLLIDE = 4'd3,
    S_LINK_ACTION   = 4'd4,
    S_MOVE_ENT      = 4'd5,
    S_DRAW_MAP      = 4'd6,
    S_DRAW_LINK     = 4'd7,
    S_DRAW_ENT      = 4'd8,
    S_PAUSE         = 4'd9,
    S_GAME_OVER     = 4'd10
  } state_t;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

endpackage

// File: rtl/game_sequencer_if.sv
// Draw-phase handshake between sequencer
// (master) and datapath draw engine (slave).
interface game_sequencer_if;

  logic draw_map;
  logic draw_link;
  logic draw_ent;
  logic draw_map_done;
  logic draw_link_done;
  logic draw_ent_done;

  modport master (
    output draw_map,
    output draw_link,
    output draw_ent,
    input  draw_map_done,
    input  draw_link_done,
    input  draw_ent_done
  );

  modport slave (
    input  draw_map,
    input  draw_link,
    input  draw_ent,
    output draw_map_done,
    output draw_link_done,
    output draw_ent_done
  );

endinterface

// File: rtl/game_sequencer_wdog.sv
// Draw-wait watchdog: counts waiting cycles,
// flags expiry on the last allowed cycle.
module seq_watchdog #(
  parameter int unsigned WDOG_CYCLES = 2000000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(WDOG_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable & (cnt == LAST);

endmodule

// File: rtl/game_sequencer.sv
// Per-frame game loop sequencer: phase FSM,
// entity channels, tick queueing, draw watchdog.
module game_sequencer
  import game_pkg::*;
#(
  parameter int N_ENT       = 4,
  parameter int IDX_W       = 2,
  parameter int FRAME_W     = 16,
  parameter int WDOG_CYCLES = 2000000
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               tick,
  input  logic               pause,
  input  logic               game_over,
  input  logic               restart,
  input  logic [N_ENT-1:0]   ent_alive,
  game_sequencer_if.master   dif,
  output logic [3:0]         state,
  output logic               init,
  output logic               idle,
  output logic               gen_move,
  output logic               check_collide,
  output logic               apply_act_link,
  output logic               move_ent,
  output logic [IDX_W-1:0]   ent_idx,
  output logic [FRAME_W-1:0] frame_count,
  output logic               tick_overrun,
  output logic               wdog_fault
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ENT - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 pend_q, pend_d;
  logic                 ovr_q, ovr_d;
  logic                 wf_q, wf_d;
  logic                 alive;
  logic                 waiting;
  logic                 done;
  logic                 wd_exp;
  logic                 wd_hit;
  logic                 wd_clr;

  assign alive = ent_alive[idx_q];

  always_comb begin
    waiting = OFF;
    done    = OFF;
    unique case (1'b1)
      state_q == S_DRAW_MAP: begin
        waiting = ON;
        done    = dif.draw_map_done;
      end
      state_q == S_DRAW_LINK: begin
        waiting = ON;
        done    = dif.draw_link_done;
      end
      state_q == S_DRAW_ENT: begin
        waiting = alive;
        done    = alive & dif.draw_ent_done;
      end
      default: ;
    endcase
  end

  // a done arriving on the expiry cycle takes precedence
  assign wd_hit = wd_exp & ~done;
  assign wd_clr = ~waiting | done | (state_d != state_q);

  seq_watchdog #(
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clock  (clock),
    .resetn (resetn),
    .clear  (wd_clr),
    .enable (waiting),
    .expire (wd_exp)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    pend_d  = pend_q | tick;
    ovr_d   = tick & pend_q;
    wf_d    = OFF;
    case (state_q)
      S_INIT: state_d = S_DRAW_MAP;
      S_IDLE: begin
        if (game_over) begin
          state_d = S_GAME_OVER;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (tick | pend_q) begin
          state_d = S_GEN_MOVE;
          pend_d  = tick & pend_q;
        end
      end
      S_GEN_MOVE:      state_d = S_CHECK_COLLIDE;
      S_CHECK_COLLIDE: state_d = S_LINK_ACTION;
      S_LINK_ACTION: begin
        state_d = S_MOVE_ENT;
        idx_d   = '0;
      end
      S_MOVE_ENT: begin
        if (idx_q == LAST) begin
          state_d = S_DRAW_MAP;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAW_MAP: begin
        if (done) state_d = S_DRAW_LINK;
      end
      S_DRAW_LINK: begin
        if (done) begin
          state_d = S_DRAW_ENT;
          idx_d   = '0;
        end
      end
      S_DRAW_ENT: begin
        if (done | ~alive) begin
          if (idx_q == LAST) begin
            state_d = S_IDLE;
            idx_d   = '0;
            frame_d = frame_q + FRAME_W'(1);
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PAUSE: begin
        if (game_over) begin
          state_d = S_GAME_OVER;
        end else if (!pause) begin
          state_d = S_DRAW_MAP;
        end
      end
      S_GAME_OVER: begin
        if (restart) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
    if (wd_hit) begin
      state_d = S_IDLE;
      idx_d   = '0;
      frame_d = frame_q;
      wf_d    = ON;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_INIT;
      idx_q   <= '0;
      frame_q <= '0;
      pend_q  <= OFF;
      ovr_q   <= OFF;
      wf_q    <= OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      wf_q    <= wf_d;
    end
  end

  assign state          = state_q;
  assign init           = state_q == S_INIT;
  assign idle           = state_q == S_IDLE;
  assign gen_move       = state_q == S_GEN_MOVE;
  assign check_collide  = state_q == S_CHECK_COLLIDE;
  assign apply_act_link = state_q == S_LINK_ACTION;
  assign move_ent       = (state_q == S_MOVE_ENT) & alive;
  assign dif.draw_map   = state_q == S_DRAW_MAP;
  assign dif.draw_link  = state_q == S_DRAW_LINK;
  assign dif.draw_ent   = (state_q == S_DRAW_ENT) & alive;
  assign ent_idx        = idx_q;
  assign frame_count    = frame_q;
  assign tick_overrun   = ovr_q;
  assign wdog_fault     = wf_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: frame pass,
// alive mask, tick queueing, watchdog, pause, reset.
module tb_game_sequencer;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        tick = 1'b0;
  logic        pause = 1'b0;
  logic        game_over = 1'b0;
  logic        restart = 1'b0;
  logic [3:0]  ent_alive = 4'b1111;
  logic        auto_map = 1'b1;
  logic        auto_link = 1'b1;
  logic        auto_ent = 1'b1;
  logic        m_map = 1'b0;
  logic        m_link = 1'b0;
  logic        m_ent = 1'b0;
  logic [3:0]  state;
  logic        init, idle, gen_move;
  logic        check_collide, apply_act_link;
  logic        move_ent;
  logic [1:0]  ent_idx;
  logic [15:0] frame_count;
  logic        tick_overrun, wdog_fault;
  int          checks = 0;
  int          errors = 0;
  int          mcnt;

  game_sequencer_if dif ();

  assign dif.draw_map_done  = auto_map  ? dif.draw_map  : m_map;
  assign dif.draw_link_done = auto_link ? dif.draw_link : m_link;
  assign dif.draw_ent_done  = auto_ent  ? dif.draw_ent  : m_ent;

  game_sequencer #(
    .N_ENT       (4),
    .IDX_W       (2),
    .FRAME_W     (16),
    .WDOG_CYCLES (16)
  ) dut (
    .clock          (clk),
    .resetn         (resetn),
    .tick           (tick),
    .pause          (pause),
    .game_over      (game_over),
    .restart        (restart),
    .ent_alive      (ent_alive),
    .dif            (dif.master),
    .state          (state),
    .init           (init),
    .idle           (idle),
    .gen_move       (gen_move),
    .check_collide  (check_collide),
    .apply_act_link (apply_act_link),
    .move_ent       (move_ent),
    .ent_idx        (ent_idx),
    .frame_count    (frame_count),
    .tick_overrun   (tick_overrun),
    .wdog_fault     (wdog_fault)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    #2 resetn = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(S_INIT));
    chk("rst_init", 32'(init), 1);
    chk("rst_idx", 32'(ent_idx), 0);
    chk("rst_frame", 32'(frame_count), 0);
    chk("rst_pulses", 32'({tick_overrun, wdog_fault}), 0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // first pass, all alive, dones echo requests
    step();
    chk("p1_map", 32'(state), 32'(S_DRAW_MAP));
    chk("p1_map_en", 32'(dif.draw_map), 1);
    step(4);
    chk("p1_ent_idx", 32'(ent_idx), 2);
    step();
    chk("p1_frame_pre", 32'(frame_count), 0);
    step();
    chk("p1_idle", 32'(state), 32'(S_IDLE));
    chk("p1_frame", 32'(frame_count), 1);

    // alive mask 0101
    ent_alive = 4'b0101;
    auto_ent = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("p2_gen", 32'(gen_move), 1);
    step(2);
    chk("p2_act", 32'(apply_act_link), 1);
    mcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("p2_mv_state", 32'(state), 32'(S_MOVE_ENT));
      chk("p2_mv_idx", 32'(ent_idx), 32'(i));
      chk("p2_mv_en", 32'(move_ent), i % 2 == 0 ? 1 : 0);
      mcnt += int'(move_ent);
    end
    chk("p2_mv_cnt", 32'(mcnt), 2);
    step(3);
    chk("p2_e0", 32'({state, ent_idx}), {S_DRAW_ENT, 2'd0});
    step(2);
    chk("p2_e0_wait", 32'({state, ent_idx}), {S_DRAW_ENT, 2'd0});
    chk("p2_e0_en", 32'(dif.draw_ent), 1);
    m_ent = 1'b1;
    step();
    m_ent = 1'b0;
    chk("p2_e1", 32'({ent_idx, dif.draw_ent}), {2'd1, 1'b0});
    step();
    chk("p2_e2", 32'({ent_idx, dif.draw_ent}), {2'd2, 1'b1});
    step();
    chk("p2_e2_wait", 32'(ent_idx), 2);
    m_ent = 1'b1;
    step();
    m_ent = 1'b0;
    chk("p2_e3", 32'({ent_idx, dif.draw_ent}), {2'd3, 1'b0});
    step();
    chk("p2_idle", 32'(state), 32'(S_IDLE));
    chk("p2_frame", 32'(frame_count), 2);

    // two ticks during one draw pass
    ent_alive = 4'b1111;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(9);
    chk("p3_e0", 32'({state, ent_idx}), {S_DRAW_ENT, 2'd0});
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("p3_ovr0", 32'(tick_overrun), 0);
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("p3_ovr1", 32'(tick_overrun), 1);
    step();
    chk("p3_ovr_clr", 32'(tick_overrun), 0);
    m_ent = 1'b1;
    step(4);
    m_ent = 1'b0;
    chk("p3_idle", 32'(state), 32'(S_IDLE));
    chk("p3_frame", 32'(frame_count), 3);
    step();
    chk("p3_pend_exit", 32'(state), 32'(S_GEN_MOVE));
    auto_ent = 1'b1;
    step(13);
    chk("p3b_idle", 32'(state), 32'(S_IDLE));
    chk("p3b_frame", 32'(frame_count), 4);
    step();
    chk("p3b_stay", 32'(state), 32'(S_IDLE));

    // stray done ignored, then watchdog on link draw
    auto_link = 1'b0;
    m_link = 1'b1;
    step();
    m_link = 1'b0;
    chk("p4_stray", 32'(state), 32'(S_IDLE));
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(8);
    chk("p4_link", 32'(state), 32'(S_DRAW_LINK));
    step(15);
    chk("p4_link_15", 32'(state), 32'(S_DRAW_LINK));
    chk("p4_nofault", 32'(wdog_fault), 0);
    step();
    chk("p4_fault", 32'(wdog_fault), 1);
    chk("p4_idle", 32'({state, ent_idx}), {S_IDLE, 2'd0});
    chk("p4_frame", 32'(frame_count), 4);
    step();
    chk("p4_fault_clr", 32'(wdog_fault), 0);
    auto_link = 1'b1;

    // pause, redraw, game over
    pause = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("p5_pause", 32'(state), 32'(S_PAUSE));
    step();
    chk("p5_no_en", 32'({idle, dif.draw_map}), 0);
    pause = 1'b0;
    step();
    chk("p5_redraw", 32'(state), 32'(S_DRAW_MAP));
    pause = 1'b1;
    step(6);
    chk("p5_idle", 32'(state), 32'(S_IDLE));
    chk("p5_frame", 32'(frame_count), 5);
    step();
    chk("p5_pause2", 32'(state), 32'(S_PAUSE));
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("p5_rst_ign", 32'(state), 32'(S_PAUSE));
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    pause = 1'b0;
    chk("p5_go", 32'(state), 32'(S_GAME_OVER));
    step();
    chk("p5_go_stay", 32'(state), 32'(S_GAME_OVER));
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("p5_restart", 32'(state), 32'(S_INIT));

    // async reset in the middle of entity draw
    auto_ent = 1'b0;
    step(3);
    m_ent = 1'b1;
    step(2);
    m_ent = 1'b0;
    chk("p6_e2", 32'({state, ent_idx}), {S_DRAW_ENT, 2'd2});
    #2 resetn = 1'b0;
    #1;
    chk("p6_state", 32'(state), 32'(S_INIT));
    chk("p6_idx", 32'(ent_idx), 0);
    chk("p6_frame", 32'(frame_count), 0);
    chk("p6_en", 32'({init, dif.draw_ent}), 32'(2'b10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
